// File: rtl/dm_waitstate_mem.sv
// Data-memory model for the CPU data port: valid/ready requests, programmable wait states,
// sequential clear after reset. Define DM_WRITE_TRACE_EN to add the registered write-trace outputs.
module dm_waitstate_mem #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        clr_busy,
`ifdef DM_WRITE_TRACE_EN
  output logic        trace_valid,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
`endif
  output logic [1:0]  dbg_state
);

  localparam int          IW     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN33 = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [IW-1:0] clr_idx;
  logic [3:0]    cnt;
  logic [31:0]   lat_addr, lat_wdata;
  logic [3:0]    lat_byteen;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   acc_addr, acc_wdata, stored, merged;
  logic [3:0]    acc_byteen;
  logic [32:0]   off33;
  logic          in_range, accept, do_access;
  logic [IW-1:0] acc_idx;

  assign dbg_state = state;

  // Handshake: a request transfers at a rising edge where req_valid and req_ready are both high;
  // req_ready is high only in IDLE, and each accepted request yields exactly one rsp_valid pulse
  // with no back-pressure on the response side.
  always_comb begin
    accept     = (state == S_IDLE) && req_valid;
    do_access  = (LATENCY == 0) ? accept : ((state == S_WAIT) && (cnt == 4'd0));
    acc_addr   = (state == S_IDLE) ? req_addr   : lat_addr;
    acc_byteen = (state == S_IDLE) ? req_byteen : lat_byteen;
    acc_wdata  = (state == S_IDLE) ? req_wdata  : lat_wdata;
    // Below-base addresses wrap past bit 31 of the 33-bit offset and fail the span test.
    off33      = {1'b0, acc_addr} - {1'b0, ADDR_BASE};
    in_range   = off33 < SPAN33;
    acc_idx    = off33[IW+1:2];
    stored     = mem[acc_idx];
    merged     = stored;
    for (int k = 0; k < 4; k++) begin
      if (acc_byteen[k]) merged[8*k +: 8] = acc_wdata[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == S_CLEAR) mem[clr_idx] <= '0;
      else if (do_access && in_range && (|acc_byteen)) mem[acc_idx] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CLEAR;
      clr_idx    <= '0;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_byteen <= '0;
      lat_wdata  <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      clr_busy   <= 1'b1;
`ifdef DM_WRITE_TRACE_EN
      trace_valid <= 1'b0;
      trace_addr  <= '0;
      trace_data  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
`ifdef DM_WRITE_TRACE_EN
      trace_valid <= 1'b0;
`endif
      case (state)
        S_CLEAR: begin
          clr_idx <= clr_idx + IW'(1);
          if (clr_idx == IW'(DEPTH_WORDS - 1)) begin
            state     <= S_IDLE;
            clr_busy  <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            lat_addr   <= req_addr;
            lat_byteen <= req_byteen;
            lat_wdata  <= req_wdata;
            req_ready  <= 1'b0;
            if (LATENCY == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else state <= S_RESP;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
      if (do_access) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= in_range ? merged : 32'h0;
        rsp_err   <= !in_range;
`ifdef DM_WRITE_TRACE_EN
        if (in_range && (|acc_byteen)) begin
          trace_valid <= 1'b1;
          trace_addr  <= {acc_addr[31:2], 2'b00};
          trace_data  <= merged;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_dm_waitstate_mem.sv
// Bench for dm_waitstate_mem: two instances (base 0 / no wait states, base 0x1000 / 3 wait states),
// random traffic checked by a scoreboard against an array-based memory model.
module tb_dm_waitstate_mem;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]       req_valid;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][3:0]  req_byteen;
  wire  [1:0]       req_ready, rsp_valid, rsp_err, clr_busy;
  wire  [1:0][31:0] rsp_rdata;
  wire  [1:0][1:0]  dbg_state;
`ifdef DM_WRITE_TRACE_EN
  wire  [1:0]       trace_valid;
  wire  [1:0][31:0] trace_addr, trace_data;
`endif

  dm_waitstate_mem #(.ADDR_BASE(32'h0000_0000), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_byteen(req_byteen[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .clr_busy(clr_busy[0]),
`ifdef DM_WRITE_TRACE_EN
    .trace_valid(trace_valid[0]), .trace_addr(trace_addr[0]), .trace_data(trace_data[0]),
`endif
    .dbg_state(dbg_state[0]));

  dm_waitstate_mem #(.ADDR_BASE(32'h0000_1000), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_byteen(req_byteen[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .clr_busy(clr_busy[1]),
`ifdef DM_WRITE_TRACE_EN
    .trace_valid(trace_valid[1]), .trace_addr(trace_addr[1]), .trace_data(trace_data[1]),
`endif
    .dbg_state(dbg_state[1]));

  int checks = 0;
  int errors = 0;

  // Entry layout: [97:66] accept edge, [65:34] trace addr, [33] trace expected, [32] err, [31:0] data
  logic [97:0] exp_q0[$];
  logic [97:0] exp_q1[$];
  logic [31:0] mdl [2][DEPTH];

  function automatic logic [31:0] base_of(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'h0000_1000;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic issue(input int i, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input bit track, output int acc);
    int n = 0;
    longint off;
    bit inr;
    int idx;
    logic [31:0] mg;
    while (!req_ready[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready[i]) begin
      errors++;
      $display("FAIL ready_timeout inst%0d: req_ready=%b after %0d cycles, required 1", i, req_ready[i], n);
      acc = -1;
      return;
    end
    off = longint'({32'h0, addr}) - longint'({32'h0, base_of(i)});
    inr = (off >= 0) && (off < 4 * DEPTH);
    mg  = 32'h0;
    if (inr) begin
      idx = int'(off / 4);
      for (int k = 0; k < 4; k++)
        mg[8*k +: 8] = be[k] ? wd[8*k +: 8] : mdl[i][idx][8*k +: 8];
      if (track && be != 4'h0) mdl[i][idx] = mg;
    end
    acc = cyc + 1;
    if (track) begin
      if (i == 0) exp_q0.push_back({32'(acc), addr & ~32'h3, inr && be != 4'h0, !inr, mg});
      else        exp_q1.push_back({32'(acc), addr & ~32'h3, inr && be != 4'h0, !inr, mg});
    end
    req_valid[i]  = 1'b1;
    req_addr[i]   = addr;
    req_byteen[i] = be;
    req_wdata[i]  = wd;
    @(negedge clk);
    req_valid[i]  = 1'b0;
    req_addr[i]   = $urandom;
    req_byteen[i] = 4'($urandom);
    req_wdata[i]  = $urandom;
  endtask

  task automatic do_reset();
    int busy_n [2];
    int nrdy_n [2];
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rsp_valid[i] !== 1'b0 || rsp_rdata[i] !== 32'h0 || rsp_err[i] !== 1'b0 ||
          clr_busy[i] !== 1'b1 || req_ready[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst%0d: valid=%b rdata=%h err=%b busy=%b ready=%b, required 0 0 0 1 0",
                 i, rsp_valid[i], rsp_rdata[i], rsp_err[i], clr_busy[i], req_ready[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      busy_n[i] = 0;
      nrdy_n[i] = 0;
      for (int w = 0; w < DEPTH; w++) mdl[i][w] = 32'h0;
    end
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 2; i++) begin
        busy_n[i] += int'(clr_busy[i]);
        nrdy_n[i] += int'(!req_ready[i]);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy_n[i] != DEPTH || nrdy_n[i] != DEPTH) begin
        errors++;
        $display("FAIL clear_length inst%0d: clr_busy cycles=%0d not-ready cycles=%0d, required %0d",
                 i, busy_n[i], nrdy_n[i], DEPTH);
      end
    end
  endtask

  task automatic mon(input int i);
    logic [97:0] e;
    bit have;
    have = (i == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
    if (rsp_valid[i]) begin
      checks++;
      if (!have) begin
        errors++;
        $display("FAIL unexpected_rsp inst%0d: got rdata=%h err=%b, required no response",
                 i, rsp_rdata[i], rsp_err[i]);
      end else begin
        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        if (rsp_rdata[i] !== e[31:0] || rsp_err[i] !== e[32]) begin
          errors++;
          $display("FAIL rsp_data inst%0d: got rdata=%h err=%b, required rdata=%h err=%b",
                   i, rsp_rdata[i], rsp_err[i], e[31:0], e[32]);
        end
        checks++;
        if (cyc - int'(e[97:66]) != lat_of(i)) begin
          errors++;
          $display("FAIL rsp_latency inst%0d: got %0d edges after accept, required %0d",
                   i, cyc - int'(e[97:66]), lat_of(i));
        end
`ifdef DM_WRITE_TRACE_EN
        checks++;
        if (trace_valid[i] !== e[33] ||
            (e[33] && (trace_addr[i] !== e[65:34] || trace_data[i] !== e[31:0]))) begin
          errors++;
          $display("FAIL trace inst%0d: got v=%b a=%h d=%h, required v=%b a=%h d=%h", i,
                   trace_valid[i], trace_addr[i], trace_data[i], e[33], e[65:34], e[31:0]);
        end
`endif
      end
    end else begin
      if (have) begin
        checks++;
        if (req_ready[i] !== 1'b0) begin
          errors++;
          $display("FAIL ready_while_busy inst%0d: req_ready=%b, required 0", i, req_ready[i]);
        end
      end
`ifdef DM_WRITE_TRACE_EN
      checks++;
      if (trace_valid[i] !== 1'b0) begin
        errors++;
        $display("FAIL trace_idle inst%0d: trace_valid=%b, required 0", i, trace_valid[i]);
      end
`endif
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) mon(i);
  end

  task automatic drain();
    int n = 0;
    while ((exp_q0.size() > 0 || exp_q1.size() > 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q0.size() > 0 || exp_q1.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d responses outstanding, required 0", exp_q0.size(), exp_q1.size());
      exp_q0.delete();
      exp_q1.delete();
    end
  endtask

  initial begin
    int acc, prev;
    logic [31:0] b, ra;
    logic [3:0] be;
    req_valid  = '0;
    req_addr   = '0;
    req_byteen = '0;
    req_wdata  = '0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      b = base_of(i);
      issue(i, b + 32'h20, 4'h0, 32'h0, 1'b1, acc);
      issue(i, b + 32'h8,  4'hF, 32'h1234_5678, 1'b1, acc);
      issue(i, b + 32'h8,  4'h0, 32'h0, 1'b1, acc);
      issue(i, b + 32'hB,  4'b0101, 32'hAABB_CCDD, 1'b1, acc);
      issue(i, b + 32'h8,  4'h0, 32'h0, 1'b1, acc);
      issue(i, b + 32'h40, 4'hF, 32'hDEAD_BEEF, 1'b1, acc);
      issue(i, b - 32'h4,  4'hF, 32'hCAFE_F00D, 1'b1, acc);
      issue(i, b + 32'h3C, 4'h0, 32'h0, 1'b1, acc);
      issue(i, b,          4'h0, 32'h0, 1'b1, acc);
      prev = -1;
      for (int k = 0; k < 6; k++) begin
        issue(i, b + 32'(4 * $urandom_range(0, DEPTH - 1)), 4'($urandom_range(0, 15)), $urandom, 1'b1, acc);
        if (prev >= 0) begin
          checks++;
          if (acc - prev != lat_of(i) + 2) begin
            errors++;
            $display("FAIL spacing inst%0d: accepts %0d cycles apart, required %0d",
                     i, acc - prev, lat_of(i) + 2);
          end
        end
        prev = acc;
      end
      for (int k = 0; k < 60; k++) begin
        ra = b - 32'h8 + 32'($urandom_range(0, 80));
        be = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        issue(i, ra, be, $urandom, 1'b1, acc);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drain();
    end
    issue(1, 32'h0000_1004, 4'hF, 32'h55AA_55AA, 1'b0, acc);
    @(negedge clk);
    do_reset();
    issue(1, 32'h0000_1004, 4'h0, 32'h0, 1'b1, acc);
    issue(0, 32'h0000_0004, 4'h0, 32'h0, 1'b1, acc);
    drain();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
